// File: rtl/kmeans_regmap_pkg.sv
// Shared definitions for the k-means register file and its upstream APB master:
// register numbering, master FSM states and the buffered host command layout.
package kmeans_regmap_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 91;

  typedef enum logic [ADDR_W-1:0] {
    INTERNAL_STATUS = 9'd0,
    GO              = 9'd1,
    CENT_1          = 9'd2,
    CENT_2          = 9'd3,
    CENT_3          = 9'd4,
    CENT_4          = 9'd5,
    CENT_5          = 9'd6,
    CENT_6          = 9'd7,
    CENT_7          = 9'd8,
    CENT_8          = 9'd9,
    RAM_ADDR        = 9'd10,
    RAM_DATA        = 9'd11,
    FIRST_RAM_ADDR  = 9'd12,
    LAST_RAM_ADDR   = 9'd13,
    THRESHOLD       = 9'd14
  } kmeans_reg_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_master_st_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } kmeans_cmd_t;

endpackage

// File: rtl/kmeans_cmd_fifo.sv
// Small synchronous command FIFO: valid/ready push side, pop strobe, and a
// separate occupancy counter so full/empty need no pointer-wrap bit.
module kmeans_cmd_fifo
  import kmeans_regmap_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push_valid && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kmeans_apb_host_master.sv
// Host-command to APB bridge for the k-means register file: buffers commands,
// runs one bounded APB transfer at a time and returns one response per command.
module kmeans_apb_host_master
  import kmeans_regmap_pkg::*;
#(
  parameter int unsigned addrWidth      = 9,
  parameter int unsigned dataWidth      = 91,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready
);

  localparam int unsigned CMD_W = 1 + addrWidth + dataWidth;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES);

  apb_master_st_t              state;
  logic [CMD_W-1:0]            head;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic [$clog2(CMD_DEPTH):0]  fifo_count;
  logic                        pop;
  logic [TW-1:0]               timer;

  assign pop       = (state == IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = (fifo_count != '0) || (state != IDLE);

  kmeans_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (cmd_valid),
    .push_data  ({cmd_write, cmd_addr, cmd_wdata}),
    .pop        (pop),
    .pop_data   (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {pwrite, paddr, pwdata} <= head;
            psel  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          timer   <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a reply on the limit cycle is not an error.
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
